// File: rtl/mul_div_unit.sv
// Iterative RV32M divider: restoring division, one quotient bit per cycle, with
// single-cycle resolution of divide-by-zero and signed overflow, and direct register-file writeback.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  op,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_addr,
    output logic        busy,
    output logic        done,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [5:0]  cnt_r;
    logic [31:0] rem_r, quo_r, dvsr_r;
    logic [1:0]  op_r;
    logic [4:0]  rd_r;
    logic        neg_q_r, neg_rem_r;
    logic        busy_r, done_r, wb_we_r;
    logic [4:0]  wb_addr_r;
    logic [31:0] wb_data_r;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic en);
        cond_neg = en ? (32'd0 - v) : v;
    endfunction

    logic        is_signed_s, accept_s, div_zero_s, ovf_s, special_s;
    logic [32:0] rem_shift_s, diff_s;
    logic        ge_s;
    logic [31:0] rem_nxt_s, quo_nxt_s, calc_res_s, spec_res_s;
    logic [31:0] wb_data_nxt_s;
    logic [4:0]  wb_addr_nxt_s;

    // Operand classification and one restoring-division step
    always_comb begin
        is_signed_s   = ~op[0];
        accept_s      = (state_r == IDLE) && start && !flush;
        div_zero_s    = (rs2_data == 32'd0);
        ovf_s         = is_signed_s && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
        special_s     = div_zero_s || ovf_s;
        rem_shift_s   = {rem_r, quo_r[31]};
        diff_s        = rem_shift_s - {1'b0, dvsr_r};
        ge_s          = ~diff_s[32];
        rem_nxt_s     = ge_s ? diff_s[31:0] : rem_shift_s[31:0];
        quo_nxt_s     = {quo_r[30:0], ge_s};
        calc_res_s    = op_r[1] ? cond_neg(rem_nxt_s, neg_rem_r) : cond_neg(quo_nxt_s, neg_q_r);
        if (div_zero_s) begin
            spec_res_s = op[1] ? rs1_data : 32'hFFFF_FFFF;
        end else begin
            spec_res_s = op[1] ? 32'h0000_0000 : 32'h8000_0000;
        end
        wb_data_nxt_s = (state_r == IDLE) ? spec_res_s : calc_res_s;
        wb_addr_nxt_s = (state_r == IDLE) ? rd_addr : rd_r;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = special_s ? DONE : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_s = IDLE;
                end else if (cnt_r == 6'd31) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch and iteration datapath; magnitudes are divided unsigned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= 6'd0;
            rem_r     <= 32'd0;
            quo_r     <= 32'd0;
            dvsr_r    <= 32'd0;
            op_r      <= 2'd0;
            rd_r      <= 5'd0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r     <= 6'd0;
            rem_r     <= 32'd0;
            quo_r     <= cond_neg(rs1_data, is_signed_s && rs1_data[31]);
            dvsr_r    <= cond_neg(rs2_data, is_signed_s && rs2_data[31]);
            op_r      <= op;
            rd_r      <= rd_addr;
            neg_q_r   <= is_signed_s && (rs1_data[31] ^ rs2_data[31]);
            neg_rem_r <= is_signed_s && rs1_data[31];
        end else if (state_r == CALC) begin
            cnt_r     <= cnt_r + 6'd1;
            rem_r     <= rem_nxt_s;
            quo_r     <= quo_nxt_s;
        end else begin
            cnt_r     <= cnt_r;
        end
    end

    // Registered outputs; writeback data and address change only on DONE entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wb_we_r   <= 1'b0;
            wb_addr_r <= 5'd0;
            wb_data_r <= 32'd0;
        end else begin
            busy_r  <= (state_s == CALC) || (state_s == DONE);
            done_r  <= (state_s == DONE);
            wb_we_r <= (state_s == DONE) && (wb_addr_nxt_s != 5'd0);
            if (state_s == DONE) begin
                wb_addr_r <= wb_addr_nxt_s;
                wb_data_r <= wb_data_nxt_s;
            end else begin
                wb_addr_r <= wb_addr_r;
                wb_data_r <= wb_data_r;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign wb_we   = wb_we_r;
    assign wb_addr = wb_addr_r;
    assign wb_data = wb_data_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus hand sequences for
// ignored starts, flush, mid-operation reset and back-to-back issue.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [4:0]  rd_addr = 5'd0;
    logic        busy, done, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_data = 32'd0;

    localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
        .busy(busy), .done(done), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one op; cycle 0 is the accepting cycle, outputs sampled on negedges.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat, input string nm);
        int cyc;
        bit busy_ok;
        @(negedge clk);
        op = o; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rs1_data = 32'h5A5A_5A5A; rs2_data = 32'd3; rd_addr = 5'd31; op = ~o;
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 60) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({nm, " latency"}, cyc, lat);
        check({nm, " busy"}, {31'd0, busy_ok & busy}, 32'd1);
        check({nm, " wb_data"}, wb_data, exp);
        check({nm, " wb_addr"}, {27'd0, wb_addr}, {27'd0, rd});
        check({nm, " wb_we"}, {31'd0, wb_we}, {31'd0, rd != 5'd0});
        @(negedge clk);
        check({nm, " done clears"}, {30'd0, done, busy}, 32'd0);
        last_data = exp;
    endtask

    initial begin
        int cyc;
        bit seen;
        vecs[0]  = '{DIV,  32'd100,       32'd7,         5'd5,  32'h0000_000E, 33};
        vecs[1]  = '{DIV,  32'hFFFF_FFF9, 32'd2,         5'd1,  32'hFFFF_FFFD, 33};
        vecs[2]  = '{REM,  32'hFFFF_FFF9, 32'd2,         5'd2,  32'hFFFF_FFFF, 33};
        vecs[3]  = '{DIVU, 32'hFFFF_FFF9, 32'd2,         5'd3,  32'h7FFF_FFFC, 33};
        vecs[4]  = '{DIVU, 32'h0000_1234, 32'd0,         5'd4,  32'hFFFF_FFFF, 1};
        vecs[5]  = '{REMU, 32'h0000_1234, 32'd0,         5'd6,  32'h0000_1234, 1};
        vecs[6]  = '{DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 1};
        vecs[7]  = '{REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h0000_0000, 1};
        vecs[8]  = '{DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h0000_0000, 33};
        vecs[9]  = '{REMU, 32'd100,       32'd7,         5'd10, 32'h0000_0002, 33};
        vecs[10] = '{DIV,  32'd7,         32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 33};
        vecs[11] = '{REM,  32'd7,         32'hFFFF_FFFE, 5'd12, 32'h0000_0001, 33};
        vecs[12] = '{DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd13, 32'h0000_000E, 33};
        vecs[13] = '{REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd14, 32'hFFFF_FFFE, 33};
        vecs[14] = '{REM,  32'hFFFF_FFF0, 32'd0,         5'd15, 32'hFFFF_FFF0, 1};
        vecs[15] = '{DIV,  32'd0,         32'd5,         5'd16, 32'h0000_0000, 33};

        #1;
        check("reset outputs", {busy, done, wb_we, wb_addr, 24'd0}, 32'd0);
        check("reset wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // rd=0 with start re-asserted during CALC
        @(negedge clk);
        op = DIV; rs1_data = 32'd9; rs2_data = 32'd3; rd_addr = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 60) begin
            start = (cyc >= 5 && cyc <= 20);
            rs1_data = 32'd1000 + cyc;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("rd0 latency", cyc, 33);
        check("rd0 wb_we", {31'd0, wb_we}, 32'd0);
        check("rd0 wb_data", wb_data, 32'd3);
        last_data = 32'd3;
        @(negedge clk);
        check("rd0 no requeue", {31'd0, busy}, 32'd0);

        // flush in cycle 10
        op = DIV; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (done || wb_we) seen = 1'b1;
            @(negedge clk);
        end
        check("flush no done", {31'd0, seen}, 32'd0);
        check("flush wb_data", wb_data, last_data);

        // reset in cycle 15 of an op
        op = DIV; rs1_data = 32'd50; rs2_data = 32'd5; rd_addr = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 15; c++) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset outputs", {busy, done, wb_we, wb_addr, 24'd0}, 32'd0);
        check("midreset wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(DIV, 32'd20, 32'd4, 5'd3, 32'h0000_0005, 33, "post-reset");

        // start together with flush in IDLE
        @(negedge clk);
        op = DIVU; rs1_data = 32'd8; rs2_data = 32'd2; rd_addr = 5'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (busy || done) seen = 1'b1;
            @(negedge clk);
        end
        check("start+flush ignored", {31'd0, seen}, 32'd0);

        // back-to-back: start held through the done cycle is taken the cycle after
        op = DIVU; rs1_data = 32'd10; rs2_data = 32'd0; rd_addr = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b1; op = REMU; rs1_data = 32'h0000_00AB; rs2_data = 32'd0; rd_addr = 5'd2;
        check("b2b first done", {31'd0, done}, 32'd1);
        check("b2b first data", wb_data, 32'hFFFF_FFFF);
        @(negedge clk);
        check("b2b not in done cycle", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b second done", {31'd0, done}, 32'd1);
        check("b2b second data", wb_data, 32'h0000_00AB);
        check("b2b second addr", {27'd0, wb_addr}, 32'd2);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
